add_16bit: RTL and testbench

- Registered 16-bit binary adder with carry-in and carry-out for datapath arithmetic.
- Combinational core is a carry-lookahead structure built from 4-bit lookahead groups; results are captured in an output register.
- A valid strobe accompanies the result.
- Also reports signed overflow and zero flags for downstream status logic.

---
 rtl/add_16bit.sv | 168 ++++++++++++++++
 tb/tb_add_16bit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/add_16bit.sv
// Registered carry-lookahead adder: 4-bit lookahead groups plus a second-level group carry network.
// Define ADD16_PIPE_EN to register the bit/group G-P stage, giving 2-cycle latency.
module add_16bit #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero
);
  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] p_s1, g_s1;
  logic [NG-1:0]    gg_s1, gp_s1;

  assign p_s1 = a ^ b;
  assign g_s1 = a & b;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      localparam int B = gi * GROUP;
      assign gp_s1[gi] = &p_s1[B +: GROUP];
      assign gg_s1[gi] = g_s1[B+3]
                       | (p_s1[B+3] & g_s1[B+2])
                       | (p_s1[B+3] & p_s1[B+2] & g_s1[B+1])
                       | (p_s1[B+3] & p_s1[B+2] & p_s1[B+1] & g_s1[B]);
    end
  endgenerate

  logic [WIDTH-1:0] p_s2, g_s2;
  logic [NG-1:0]    gg_s2, gp_s2;
  logic             cin_s2, vld_s2;

`ifdef ADD16_PIPE_EN
  logic [WIDTH-1:0] p_d, p_q, g_d, g_q;
  logic [NG-1:0]    gg_d, gg_q, gp_d, gp_q;
  logic             cin_d, cin_q, vld_d, vld_q;

  // Operand-derived state only loads on valid so idle X operands never enter the pipe.
  always_comb begin
    p_d   = p_q;
    g_d   = g_q;
    gg_d  = gg_q;
    gp_d  = gp_q;
    cin_d = cin_q;
    vld_d = in_valid;
    if (in_valid) begin
      p_d   = p_s1;
      g_d   = g_s1;
      gg_d  = gg_s1;
      gp_d  = gp_s1;
      cin_d = carryIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      g_q   <= '0;
      gg_q  <= '0;
      gp_q  <= '0;
      cin_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      g_q   <= g_d;
      gg_q  <= gg_d;
      gp_q  <= gp_d;
      cin_q <= cin_d;
      vld_q <= vld_d;
    end
  end

  assign p_s2   = p_q;
  assign g_s2   = g_q;
  assign gg_s2  = gg_q;
  assign gp_s2  = gp_q;
  assign cin_s2 = cin_q;
  assign vld_s2 = vld_q;
`else
  assign p_s2   = p_s1;
  assign g_s2   = g_s1;
  assign gg_s2  = gg_s1;
  assign gp_s2  = gp_s1;
  assign cin_s2 = carryIn;
  assign vld_s2 = in_valid;
`endif

  logic [NG:0]    c_grp;
  logic [WIDTH:0] c_bit;
  logic           acc, prod;

  // Group carries are flattened sum-of-products over all lower groups, not a ripple chain.
  always_comb begin
    c_grp    = '0;
    c_bit    = '0;
    acc      = 1'b0;
    prod     = 1'b0;
    c_grp[0] = cin_s2;
    for (int k = 0; k < NG; k++) begin
      acc  = gg_s2[k];
      prod = gp_s2[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc  = acc | (prod & gg_s2[j]);
        prod = prod & gp_s2[j];
      end
      c_grp[k+1] = acc | (prod & cin_s2);
    end
    for (int k = 0; k < NG; k++) begin
      c_bit[k*GROUP] = c_grp[k];
      for (int i = 1; i < GROUP; i++) begin
        c_bit[k*GROUP+i] = g_s2[k*GROUP+i-1] | (p_s2[k*GROUP+i-1] & c_bit[k*GROUP+i-1]);
      end
    end
    c_bit[WIDTH] = c_grp[NG];
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q, valid_d, valid_q;
  logic [WIDTH-1:0] sum_new;

  assign sum_new = p_s2 ^ c_bit[WIDTH-1:0];

  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    valid_d = vld_s2;
    if (vld_s2) begin
      sum_d  = sum_new;
      cout_d = c_bit[WIDTH];
      ovf_d  = c_bit[WIDTH-1] ^ c_bit[WIDTH];
      zero_d = ~|sum_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign carryOut  = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_add_16bit.sv
// Self-checking bench for add_16bit: directed cases plus random traffic against an arithmetic model.
module tb_add_16bit;
  localparam int W = 16;
`ifdef ADD16_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         carryIn;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         carryOut, overflow, zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  add_16bit #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .carryIn(carryIn),
    .out_valid(out_valid), .sum(sum), .carryOut(carryOut), .overflow(overflow), .zero(zero)
  );

  // Reference: results travel through a latency queue and are computed with plain wide addition.
  typedef struct {
    logic         v;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;
  res_t         pipe_m[$];
  logic         m_valid, m_cout, m_ovf, m_zero;
  logic [W-1:0] m_sum;

  task automatic reset_model();
    res_t e;
    e.v = 1'b0; e.s = '0; e.c = 1'b0; e.o = 1'b0;
    pipe_m.delete();
    for (int i = 0; i < LAT - 1; i++) pipe_m.push_back(e);
    m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
  endtask

  task automatic step(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    logic [W:0] full;
    res_t       e;
    in_valid = v; a = ta; b = tb; carryIn = tc;
    @(posedge clk);
    #1;
    full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    e.v = v;
    e.s = full[W-1:0];
    e.c = full[W];
    e.o = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
    pipe_m.push_back(e);
    e = pipe_m.pop_front();
    if (e.v === 1'b1) begin
      m_sum = e.s; m_cout = e.c; m_ovf = e.o; m_zero = (e.s == '0);
    end
    m_valid = e.v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; carryIn = 1'b0;
    #12;
    n_checks++;
    if ({out_valid, sum, carryOut, overflow, zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b sum=%h c=%b o=%b z=%b, want all 0",
               out_valid, sum, carryOut, overflow, zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h0001, 16'hF0F0, 16'h00FF, 16'h0005, 16'h7FFF, 16'h8000};
    logic [W-1:0] tb [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h8000};
    logic         tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] es [6] = '{16'h0002, 16'hF0F1, 16'h0100, 16'h0007, 16'h8000, 16'h0000};
    logic [2:0]   ef [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b111};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ta[i], tb[i], tc[i]);
      repeat (LAT - 1) step(1'b0, '0, '0, 1'b0);
      n_checks++;
      if ({out_valid, sum, carryOut, overflow, zero} !== {1'b1, es[i], ef[i]}) begin
        n_fail++;
        $display("FAIL directed_%0d: got v=%b sum=%h c/o/z=%b%b%b, want v=1 sum=%h c/o/z=%b",
                 i, out_valid, sum, carryOut, overflow, zero, es[i], ef[i]);
      end
      $display("directed %0d: %h + %h + %b -> sum=%h c=%b o=%b z=%b", i, ta[i], tb[i], tc[i],
               sum, carryOut, overflow, zero);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < LAT + 2; i++) begin
      if (i == 0)      step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
      else if (i == 1) step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      else             step(1'b0, '0, '0, 1'b0);
      if (i == LAT - 1) begin
        n_checks++;
        if ({out_valid, sum, carryOut, overflow, zero} !== {1'b1, 16'h0000, 3'b101}) begin
          n_fail++;
          $display("FAIL b2b_wrap: got v=%b sum=%h c/o/z=%b%b%b, want v=1 sum=0000 c/o/z=101",
                   out_valid, sum, carryOut, overflow, zero);
        end
      end else if (i == LAT) begin
        n_checks++;
        if ({out_valid, sum, carryOut, overflow, zero} !== {1'b1, 16'hFFFF, 3'b100}) begin
          n_fail++;
          $display("FAIL b2b_max: got v=%b sum=%h c/o/z=%b%b%b, want v=1 sum=FFFF c/o/z=100",
                   out_valid, sum, carryOut, overflow, zero);
        end
      end else if (i == LAT + 1) begin
        n_checks++;
        if ({out_valid, sum} !== {1'b0, 16'hFFFF}) begin
          n_fail++;
          $display("FAIL b2b_idle_hold: got v=%b sum=%h, want v=0 sum=FFFF", out_valid, sum);
        end
      end
      $display("b2b cycle %0d: v=%b sum=%h c=%b o=%b z=%b", i, out_valid, sum, carryOut, overflow, zero);
    end
  endtask

  task automatic test_idle_x();
    step(1'b1, 16'h1234, 16'h4321, 1'b1);
    for (int i = 0; i < LAT + 2; i++) begin
      step(1'b0, 'x, 'x, 1'bx);
      n_checks++;
      if ($isunknown({out_valid, sum, carryOut, overflow, zero}) ||
          {out_valid, sum, carryOut, overflow, zero} !== {m_valid, m_sum, m_cout, m_ovf, m_zero}) begin
        n_fail++;
        $display("FAIL idle_x_%0d: got v=%b sum=%h c/o/z=%b%b%b, want v=%b sum=%h c/o/z=%b%b%b", i,
                 out_valid, sum, carryOut, overflow, zero, m_valid, m_sum, m_cout, m_ovf, m_zero);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'hAAAA, 16'h5555, 1'b1);
    in_valid = 1'b1; a = 16'h0F0F; b = 16'h0101; carryIn = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    reset_model();
    n_checks++;
    if ({out_valid, sum, carryOut, overflow, zero} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b sum=%h c/o/z=%b%b%b, want all 0 before any edge",
               out_valid, sum, carryOut, overflow, zero);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      step(1'b0, '0, '0, 1'b0);
      n_checks++;
      if ({out_valid, sum, carryOut, overflow, zero} !== {m_valid, m_sum, m_cout, m_ovf, m_zero}) begin
        n_fail++;
        $display("FAIL post_reset_%0d: got v=%b sum=%h, want v=%b sum=%h", i, out_valid, sum, m_valid, m_sum);
      end
    end
    $display("async reset: released, v=%b sum=%h", out_valid, sum);
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = 16'hFFFF;
      1:       v = 16'h7FFF;
      2:       v = 16'h8000;
      3:       v = 16'h0000;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0)
        step(1'b0, 'x, 'x, 1'bx);
      else
        step(1'b1, pick_operand(), pick_operand(), 1'($urandom));
      n_checks++;
      if ({out_valid, sum, carryOut, overflow, zero} !== {m_valid, m_sum, m_cout, m_ovf, m_zero}) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_%0d: got v=%b sum=%h c/o/z=%b%b%b, want v=%b sum=%h c/o/z=%b%b%b", i,
                   out_valid, sum, carryOut, overflow, zero, m_valid, m_sum, m_cout, m_ovf, m_zero);
      end
    end
    $display("random: 10000 cycles compared, %0d errors", errs);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_idle_x();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
